program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// - Serial boot loader that sits upstream of the system Memory, beside the CPU.
// - Receives a framed byte stream and writes it into Memory one byte lane at a time.
// - Holds the CPU in reset until a frame loads and its checksum verifies.
// - While the load is in progress it owns the Memory port; after that it passes the CPU bus through.
// PARAMETERS
// - ADDR_W   17     Word-address width of the Memory port (bits [15:31] on the bus).
// - TIMEOUT  65535  Idle cycles allowed between bytes inside a frame. 0 disables the timeout.
// PORTS
// - clock        in   1       System clock. All logic is on its rising edge.
// - reset        in   1       Synchronous, active-low. 0 = reset.
// - rx_valid     in   1       A byte is offered on rx_data.
// - rx_data      in   [0:7]   Offered byte.
// - rx_ready     out  1       Loader accepts the byte. Transfer occurs when rx_valid & rx_ready.
// - cpu_address  in   ADDR_W  CPU memory address. Passed through when cpu_hold = 0.
// - cpu_data     in   [0:31]  CPU write data. Passed through when cpu_hold = 0.
// - cpu_write_en in   [0:3]   CPU byte write enables. Passed through when cpu_hold = 0.
// - mem_address  out  ADDR_W  Memory address.
// - mem_data     out  [0:31]  Memory write data.
// - mem_write_en out  [0:3]   Memory byte enables. [0] selects bits 0:7, [3] selects bits 24:31.
// - cpu_hold     out  1       Reset request to the CPU. 1 = CPU held in reset.
// - done         out  1       Frame loaded and checksum verified. Sticky until reset.
// - error        out  1       Checksum mismatch. Sticky until reset.
// BEHAVIOUR
// - Frame format: A5, ADDR_H, ADDR_L, CNT_H, CNT_L, then 4*CNT data bytes, then CSUM.
//   - ADDR is the start word address, zero-extended to ADDR_W. CNT is the word count.
//   - Data bytes are big-endian within a word: the first byte goes to lane 0.
//   - CSUM is the sum of all data bytes, modulo 256.
// - States: HUNT -> AH -> AL -> CH -> CL -> DATA -> CSUM -> DONE or ERROR.
//   - HUNT discards every byte except A5.
//   - From CL: if CNT = 0, go to CSUM; otherwise go to DATA.
//   - DATA leaves after the 4*CNT-th byte.
//   - In CSUM: match goes to DONE, mismatch goes to ERROR.
// - rx_ready is 1 in HUNT through CSUM and 0 in DONE and ERROR. It is a pure function of state.
// - Write timing for each accepted data byte:
//   - The byte is accepted at edge t.
//   - During the cycle after t (registered), mem_write_en is one-hot on lane k = byte index mod 4.
//   - mem_data carries the byte replicated on all four lanes.
//   - mem_address = ADDR + byte index / 4.
//   - Write enables are asserted for exactly one cycle per byte and are 0 otherwise.
// - Address increment: 17-bit add. The maximum address is 0xFFFF + 0xFFFE = 0x1FFFD, so the address never wraps.
// - cpu_hold = 1 from reset until DONE.
//   - It falls on the edge on which the CSUM byte is accepted and the checksum matches.
//   - In ERROR it stays 1 permanently.
// - Bus mux: if cpu_hold = 1, mem_* come from the loader registers; if cpu_hold = 0, mem_* = cpu_* (combinational).
// - Timeout, in states AH through CSUM:
//   - An idle counter resets on each accepted byte.
//   - When it reaches TIMEOUT, the loader returns to HUNT and drops the partial frame.
//   - Words already written stay in Memory.
// - A byte that arrives in the same cycle the timeout expires is dropped. The timeout wins.
// - A5 seen mid-frame is ordinary data. There is no resync until HUNT.
// - Reset values: state HUNT, cpu_hold 1, done 0, error 0, mem_write_en 0, checksum 0, counters 0.
// - Reset asserted mid-frame aborts at the next edge. No write is issued after that edge.
// TESTING
// 1. Send A5 00 10 00 01 DE AD BE EF 38.
//    -> Writes to address 0x10 on lanes 0,1,2,3 in order: DE, AD, BE, EF.
//    -> done = 1, cpu_hold = 0. Memory word 0x10 reads DEADBEEF.
// 2. Send 00 FF 5A, then the frame from test 1.
//    -> The leading junk is ignored and the result is identical to test 1.
// 3. Send the frame from test 1 with CSUM = 39.
//    -> error = 1, done = 0, cpu_hold = 1, rx_ready = 0. Word 0x10 is still written.
// 4. Send A5 FF FF 00 02, then eight data bytes 01..08, then CSUM 24.
//    -> Writes go to 0xFFFF and 0x10000. done = 1.
// 5. Set TIMEOUT = 8. Send A5 00, stall 8 cycles, then send the frame from test 1.
//    -> The first frame is abandoned and the second loads. done = 1.
// 6. Pull reset low after byte 7 of test 1.
//    -> No further mem_write_en. State HUNT, cpu_hold = 1.
//    -> A fresh frame then loads normally.

Source files
------------

// File: rtl/program_loader_if.sv
// Bus bundle for the program loader: serial byte handshake, CPU memory
// request bus and the Memory port.
//   rx_valid/rx_data/rx_ready             : byte stream handshake
//   cpu_address/cpu_data/cpu_write_en     : CPU write request
//   mem_address/mem_data/mem_write_en     : Memory write port
// slave  = the loader's view, master = the environment's view.
interface program_loader_if #(
   parameter int unsigned ADDR_W = 17
);
   logic              rx_valid;
   logic [0:7]        rx_data;
   logic              rx_ready;
   logic [ADDR_W-1:0] cpu_address;
   logic [0:31]       cpu_data;
   logic [0:3]        cpu_write_en;
   logic [ADDR_W-1:0] mem_address;
   logic [0:31]       mem_data;
   logic [0:3]        mem_write_en;

   modport slave (
      input  rx_valid, rx_data, cpu_address, cpu_data, cpu_write_en,
      output rx_ready, mem_address, mem_data, mem_write_en
   );

   modport master (
      output rx_valid, rx_data, cpu_address, cpu_data, cpu_write_en,
      input  rx_ready, mem_address, mem_data, mem_write_en
   );
endinterface

// File: rtl/program_loader.sv
// Serial boot loader. Parses frames of the form
//   A5, ADDR_H, ADDR_L, CNT_H, CNT_L, 4*CNT data bytes, CSUM
// and writes every data byte into Memory as a single-lane write. Keeps the
// CPU in reset until a frame verifies, then hands the Memory port to the CPU.
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-low
//   bus      : program_loader_if.slave (rx handshake, CPU bus in, Memory port out)
//   cpu_hold : 1 = CPU held in reset
//   done     : frame loaded and checksum verified (sticky)
//   error    : checksum mismatch (sticky)
module program_loader #(
   parameter int unsigned ADDR_W  = 17,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic                   clock,
   input  logic                   reset,
   program_loader_if.slave        bus,
   output logic                   cpu_hold,
   output logic                   done,
   output logic                   error
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned IDLE_W = 16;
   localparam logic [7:0]  SYNC   = 8'hA5;
   // Last idle count before expiry: a byte on the TIMEOUT-th cycle is too late.
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_HUNT, S_AH, S_AL, S_CH, S_CL, S_DATA, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        lane_q, lane_d;
   logic [7:0]        sum_q, sum_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [0:3]        wen_q, wen_d;
   logic [0:31]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic [7:0]        rx_byte;
   logic              ready_c;
   logic              active_c;
   logic              expire_c;
   logic              accept_c;
   logic [CNT_W-1:0]  cnt_full_c;

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_HUNT;
         addr_q  <= '0;
         cnt_q   <= '0;
         lane_q  <= '0;
         sum_q   <= '0;
         idle_q  <= '0;
         wen_q   <= '0;
         wdata_q <= '0;
         waddr_q <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
         sum_q   <= sum_d;
         idle_q  <= idle_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   // Frame parser, write generation and idle timeout
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      lane_d  = lane_q;
      sum_d   = sum_q;
      idle_d  = '0;
      wen_d   = '0;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      hold_d  = hold_q;
      done_d  = done_q;
      error_d = error_q;

      rx_byte    = bus.rx_data;
      ready_c    = (state_q != S_DONE) && (state_q != S_ERROR);
      active_c   = ready_c && (state_q != S_HUNT);
      expire_c   = (TIMEOUT != 0) && active_c && (idle_q == IDLE_LAST);
      // Timeout wins over a byte offered in the same cycle.
      accept_c   = bus.rx_valid && ready_c && !expire_c;
      cnt_full_c = {cnt_q[15:8], rx_byte};

      if (active_c && !accept_c && !expire_c && (TIMEOUT != 0)) begin
         idle_d = idle_q + IDLE_W'(1);
      end

      if (expire_c) begin
         state_d = S_HUNT;
      end else if (accept_c) begin
         case (state_q)
            S_HUNT: begin
               if (rx_byte == SYNC) begin
                  state_d = S_AH;
                  addr_d  = '0;
                  cnt_d   = '0;
                  lane_d  = '0;
                  sum_d   = '0;
               end
            end
            S_AH: begin
               addr_d  = ADDR_W'({rx_byte, 8'h00});
               state_d = S_AL;
            end
            S_AL: begin
               addr_d  = addr_q | ADDR_W'(rx_byte);
               state_d = S_CH;
            end
            S_CH: begin
               cnt_d   = {rx_byte, 8'h00};
               state_d = S_CL;
            end
            S_CL: begin
               cnt_d   = cnt_full_c;
               state_d = (cnt_full_c == '0) ? S_CSUM : S_DATA;
            end
            S_DATA: begin
               wen_d[lane_q] = 1'b1;
               wdata_d       = {4{rx_byte}};
               waddr_d       = addr_q;
               sum_d         = sum_q + rx_byte;
               lane_d        = lane_q + 2'd1;
               // Word complete: advance address, leave after the last word.
               if (lane_q == 2'd3) begin
                  addr_d = addr_q + ADDR_W'(1);
                  cnt_d  = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = S_CSUM;
                  end
               end
            end
            S_CSUM: begin
               if (rx_byte == sum_q) begin
                  state_d = S_DONE;
                  hold_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   assign bus.rx_ready = ready_c;
   assign cpu_hold     = hold_q;
   assign done         = done_q;
   assign error        = error_q;

   // Memory port owner: loader while the CPU is held, CPU afterwards.
   assign bus.mem_address  = hold_q ? waddr_q : bus.cpu_address;
   assign bus.mem_data     = hold_q ? wdata_q : bus.cpu_data;
   assign bus.mem_write_en = hold_q ? wen_q   : bus.cpu_write_en;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames, scoreboard of
// expected Memory writes, and a small model of the Memory behind the loader.
module tb_program_loader;

   localparam int unsigned ADDR_W = 17;

   typedef struct packed {
      logic [16:0] addr;
      logic [31:0] data;
      logic [3:0]  wen;
   } wr_t;

   logic clock;
   logic reset;
   logic cpu_hold;
   logic done;
   logic error;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b1;

   wr_t         exp_q[$];
   logic [31:0] mem[int];

   logic [7:0] f1[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
   logic [7:0] f4[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

   program_loader_if #(.ADDR_W(ADDR_W)) bus ();

   program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory monitor: pops the scoreboard and updates the Memory model.
   always @(negedge clock) begin
      wr_t obs;
      wr_t e;
      if (mon_en && (bus.mem_write_en !== 4'b0000)) begin
         obs = {bus.mem_address, bus.mem_data, bus.mem_write_en};
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_write observed=%h expected=none", obs);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            assert (obs === e) else begin
               bad++;
               $error("FAIL write observed=%h expected=%h", obs, e);
            end
         end
         if (!mem.exists(int'(obs.addr))) mem[int'(obs.addr)] = 32'h0;
         for (int k = 0; k < 4; k++) begin
            if (obs.wen[3-k]) mem[int'(obs.addr)][31-8*k -: 8] = obs.data[31-8*k -: 8];
         end
      end
   end

   task automatic push_wr(input logic [16:0] a, input logic [7:0] b, input int lane);
      exp_q.push_back({a, {4{b}}, 4'(4'b1000 >> lane)});
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (!bus.rx_ready && n < 16) begin
         @(posedge clock); #1;
         n++;
      end
      chk("rx_ready_wait", 64'(n < 16), 64'(1));
      @(posedge clock); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [7:0] d[$],
                             input logic [7:0] cs, input bit exp_wr);
      logic [15:0] n;
      n = 16'(d.size() / 4);
      send_byte(8'hA5);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      send_byte(n[15:8]);
      send_byte(n[7:0]);
      foreach (d[i]) begin
         if (exp_wr) push_wr(17'(a) + 17'(i / 4), d[i], i % 4);
         send_byte(d[i]);
      end
      send_byte(cs);
   endtask

   task automatic do_reset();
      bus.rx_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_hold",  64'(cpu_hold), 64'(1));
      chk("rst_done",  64'(done), 64'(0));
      chk("rst_error", 64'(error), 64'(0));
      chk("rst_ready", 64'(bus.rx_ready), 64'(1));
      chk("rst_wen",   64'(bus.mem_write_en), 64'(0));
      reset = 1'b1;
      mem.delete();
   endtask

   task automatic check_ok(input string tag);
      chk({tag, "_done"},  64'(done), 64'(1));
      chk({tag, "_hold"},  64'(cpu_hold), 64'(0));
      chk({tag, "_error"}, 64'(error), 64'(0));
      chk({tag, "_ready"}, 64'(bus.rx_ready), 64'(0));
      chk({tag, "_sb"},    64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      bus.rx_valid     = 1'b0;
      bus.rx_data      = 8'h00;
      bus.cpu_address  = '0;
      bus.cpu_data     = '0;
      bus.cpu_write_en = '0;
      reset            = 1'b0;

      // Test 1: basic frame
      do_reset();
      send_frame(16'h0010, f1, 8'h38, 1'b1);
      check_ok("t1");
      chk("t1_word", 64'(mem[16]), 64'h0000_0000_DEAD_BEEF);

      // CPU pass-through after release
      mon_en = 1'b0;
      bus.cpu_address  = 17'h1_2345;
      bus.cpu_data     = 32'hCAFE_F00D;
      bus.cpu_write_en = 4'b0101;
      #1;
      chk("pt_addr", 64'(bus.mem_address), 64'h1_2345);
      chk("pt_data", 64'(bus.mem_data), 64'hCAFE_F00D);
      chk("pt_wen",  64'(bus.mem_write_en), 64'h5);
      bus.cpu_write_en = '0;
      bus.cpu_address  = '0;
      bus.cpu_data     = '0;
      @(posedge clock); #1;
      mon_en = 1'b1;

      // Test 2: leading junk
      do_reset();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      send_frame(16'h0010, f1, 8'h38, 1'b1);
      check_ok("t2");
      chk("t2_word", 64'(mem[16]), 64'h0000_0000_DEAD_BEEF);

      // Test 3: bad checksum
      do_reset();
      send_frame(16'h0010, f1, 8'h39, 1'b1);
      chk("t3_error", 64'(error), 64'(1));
      chk("t3_done",  64'(done), 64'(0));
      chk("t3_hold",  64'(cpu_hold), 64'(1));
      chk("t3_ready", 64'(bus.rx_ready), 64'(0));
      chk("t3_word",  64'(mem[16]), 64'h0000_0000_DEAD_BEEF);
      repeat (12) @(posedge clock);
      #1;
      chk("t3_sticky", 64'({error, done, cpu_hold}), 64'b101);

      // Test 4: two words crossing 0xFFFF
      do_reset();
      send_frame(16'hFFFF, f4, 8'h24, 1'b1);
      check_ok("t4");
      chk("t4_w0", 64'(mem[17'h0FFFF]), 64'h0102_0304);
      chk("t4_w1", 64'(mem[17'h10000]), 64'h0506_0708);

      // Test 5: abandoned frame after 8 idle cycles, then a good frame
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h00);
      repeat (8) @(posedge clock);
      #1;
      send_frame(16'h0010, f1, 8'h38, 1'b1);
      check_ok("t5");

      // Timeout boundary: frame start lands on the expiring cycle and is lost
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h00);
      repeat (7) @(posedge clock);
      #1;
      send_frame(16'h0010, f1, 8'h38, 1'b0);
      chk("tb_done",  64'(done), 64'(0));
      chk("tb_hold",  64'(cpu_hold), 64'(1));
      chk("tb_ready", 64'(bus.rx_ready), 64'(1));
      chk("tb_sb",    64'(exp_q.size()), 64'(0));

      // Test 6: reset after byte 7
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h01);
      push_wr(17'h10, 8'hDE, 0);
      send_byte(8'hDE);
      push_wr(17'h10, 8'hAD, 1);
      send_byte(8'hAD);
      reset = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk("t6_hold",  64'(cpu_hold), 64'(1));
      chk("t6_ready", 64'(bus.rx_ready), 64'(1));
      chk("t6_done",  64'(done), 64'(0));
      chk("t6_wen",   64'(bus.mem_write_en), 64'(0));
      chk("t6_sb",    64'(exp_q.size()), 64'(0));
      reset = 1'b1;
      mem.delete();
      send_frame(16'h0010, f1, 8'h38, 1'b1);
      check_ok("t6");
      chk("t6_word", 64'(mem[16]), 64'h0000_0000_DEAD_BEEF);

      repeat (4) @(posedge clock);
      #1;
      chk("final_sb", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
